// File: rtl/cache_plru_tree_pkg.sv
// Shared types, defaults and tree-walk helpers for the tree pseudo-LRU controller.
// Helpers operate on a fixed-size node vector so one function serves every WAYS up to 64.
package cache_plru_tree_pkg;

    localparam int DEF_WAYS        = 4;
    localparam int DEF_SETS        = 64;
    localparam int PLRU_MAX_LEVELS = 6;
    localparam int PLRU_EXT        = 128;
    localparam int PLRU_IDX_W      = 7;

    typedef logic [PLRU_EXT-1:0]        plru_ext_t;
    typedef logic [PLRU_IDX_W-1:0]      plru_idx_t;
    typedef logic [PLRU_MAX_LEVELS-1:0] plru_way_t;

    function automatic plru_idx_t plru_left(input plru_idx_t n);
        return {n[PLRU_IDX_W-2:0], 1'b1};
    endfunction

    function automatic plru_idx_t plru_right(input plru_idx_t n);
        return {n[PLRU_IDX_W-2:0], 1'b0} + plru_idx_t'(2);
    endfunction

    // Set every node on the path to 'way' to that way's index bit, MSB at the root.
    function automatic plru_ext_t plru_touch(input plru_ext_t tree, input plru_way_t way,
                                             input int levels);
        plru_ext_t t;
        plru_idx_t node;
        plru_way_t w;
        t    = tree;
        node = '0;
        w    = way << (PLRU_MAX_LEVELS - levels);
        for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < levels) begin
                t[node] = w[PLRU_MAX_LEVELS-1];
                node    = w[PLRU_MAX_LEVELS-1] ? plru_right(node) : plru_left(node);
                w       = w << 1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/cache_plru_tree_if.sv
// Access bus of the PLRU controller: touch, victim query/result and set invalidate.
interface cache_plru_tree_if
    import cache_plru_tree_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic             touch_valid;
    logic [SET_W-1:0] touch_set;
    logic [WAY_W-1:0] touch_way;
    logic             vic_req;
    logic [SET_W-1:0] vic_set;
    logic [WAYS-1:0]  vic_valid_mask;
    logic [WAYS-1:0]  vic_lock_mask;
    logic             vic_alloc;
    logic             inv;
    logic [SET_W-1:0] inv_set;
    logic             vic_ack;
    logic [WAY_W-1:0] vic_way;
    logic             vic_none;

    modport master (
        output touch_valid, touch_set, touch_way,
        output vic_req, vic_set, vic_valid_mask, vic_lock_mask, vic_alloc,
        output inv, inv_set,
        input  vic_ack, vic_way, vic_none
    );

    modport slave (
        input  touch_valid, touch_set, touch_way,
        input  vic_req, vic_set, vic_valid_mask, vic_lock_mask, vic_alloc,
        input  inv, inv_set,
        output vic_ack, vic_way, vic_none
    );
endinterface

// File: rtl/cache_plru_tree_victim_sel.sv
// Combinational victim choice: first unlocked invalid way, else a lock-aware tree walk.
module plru_victim_sel
    import cache_plru_tree_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic [WAYS-1:0]  lock_mask,
    output logic [WAY_W-1:0] way,
    output logic             none
);
    logic [WAYS-2:0]  left_avail;
    logic [WAYS-2:0]  right_avail;
    plru_ext_t        tree_ext;
    plru_ext_t        left_ext;
    plru_ext_t        right_ext;
    plru_idx_t        node;
    plru_way_t        walk_bits;
    logic             go_right;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;

    // Heap-ordered nodes; a subtree is available if any leaf under it is unlocked.
    for (genvar gi = 0; gi < WAYS - 1; gi++) begin : g_node
        logic l_av;
        logic r_av;
        logic av;
        if (2 * gi + 1 >= WAYS - 1) begin : g_leaf
            assign l_av = ~lock_mask[2 * gi + 1 - (WAYS - 1)];
            assign r_av = ~lock_mask[2 * gi + 2 - (WAYS - 1)];
        end else begin : g_inner
            assign l_av = g_node[2 * gi + 1].av;
            assign r_av = g_node[2 * gi + 2].av;
        end
        assign av              = l_av | r_av;
        assign left_avail[gi]  = l_av;
        assign right_avail[gi] = r_av;
    end

    assign tree_ext  = plru_ext_t'(tree);
    assign left_ext  = plru_ext_t'(left_avail);
    assign right_ext = plru_ext_t'(right_avail);
    assign none      = ~(left_avail[0] | right_avail[0]);

    always_comb begin
        node      = '0;
        walk_bits = '0;
        go_right  = 1'b0;
        for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < WAY_W) begin
                go_right = ~tree_ext[node];
                if (go_right && !right_ext[node]) begin
                    go_right = 1'b0;
                end else if (!go_right && !left_ext[node]) begin
                    go_right = 1'b1;
                end
                walk_bits = {walk_bits[PLRU_MAX_LEVELS-2:0], go_right};
                node      = go_right ? plru_right(node) : plru_left(node);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_mask[i] && !lock_mask[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end
    end

    assign way = none ? '0 : (inv_found ? inv_way : walk_bits[WAY_W-1:0]);

endmodule

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU replacement state for SETS sets with a registered, lock-aware victim query.
module cache_plru_tree
    import cache_plru_tree_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cache_plru_tree_if.slave  bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic [WAYS-2:0]  tree_rd [SETS];
    logic [WAYS-2:0]  vic_tree;
    logic [WAY_W-1:0] sel_way;
    logic             sel_none;
    logic             alloc_fire;
    logic             vic_ack_reg;
    logic [WAY_W-1:0] vic_way_reg;
    logic             vic_none_reg;

    assign vic_tree = tree_rd[bus.vic_set];

    plru_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .tree       (vic_tree),
        .valid_mask (bus.vic_valid_mask),
        .lock_mask  (bus.vic_lock_mask),
        .way        (sel_way),
        .none       (sel_none)
    );

    assign alloc_fire = bus.vic_req & bus.vic_alloc & ~sel_none;

    // Per-set update: touch, then allocate, then invalidate, so later writes win.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
        logic [WAYS-2:0] tree_reg;
        logic [WAYS-2:0] tree_next;
        plru_ext_t       t_ext;

        always_comb begin
            t_ext = plru_ext_t'(tree_reg);
            if (bus.touch_valid && bus.touch_set == SET_W'(gi)) begin
                t_ext = plru_touch(t_ext, plru_way_t'(bus.touch_way), WAY_W);
            end
            if (alloc_fire && bus.vic_set == SET_W'(gi)) begin
                t_ext = plru_touch(t_ext, plru_way_t'(sel_way), WAY_W);
            end
            tree_next = t_ext[WAYS-2:0];
            if (bus.inv && bus.inv_set == SET_W'(gi)) begin
                tree_next = '0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                tree_reg <= '0;
            end else begin
                tree_reg <= tree_next;
            end
        end

        assign tree_rd[gi] = tree_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vic_ack_reg  <= 1'b0;
            vic_way_reg  <= '0;
            vic_none_reg <= 1'b0;
        end else begin
            vic_ack_reg <= bus.vic_req;
            if (bus.vic_req) begin
                vic_way_reg  <= sel_way;
                vic_none_reg <= sel_none;
            end
        end
    end

    assign bus.vic_ack  = vic_ack_reg;
    assign bus.vic_way  = vic_way_reg;
    assign bus.vic_none = vic_none_reg;

endmodule

// File: tb/tb_cache_plru_tree.sv
// Directed bench for cache_plru_tree: a 4-way/64-set and an 8-way/16-set instance.
module tb_cache_plru_tree;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    cache_plru_tree_if #(.WAYS(4), .SETS(64)) bus4 ();
    cache_plru_tree_if #(.WAYS(8), .SETS(16)) bus8 ();

    cache_plru_tree #(.WAYS(4), .SETS(64)) dut4 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus4.slave)
    );

    cache_plru_tree #(.WAYS(8), .SETS(16)) dut8 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus8.slave)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic touch4(input int set, input int way);
        bus4.touch_valid = 1'b1;
        bus4.touch_set   = 6'(set);
        bus4.touch_way   = 2'(way);
        tick();
        bus4.touch_valid = 1'b0;
        $display("touch4 set=%0d way=%0d", set, way);
    endtask

    task automatic query4(input string tag, input int set, input logic [3:0] valid,
                          input logic [3:0] lock, input logic alloc,
                          input int exp_way, input logic exp_none);
        bus4.vic_req        = 1'b1;
        bus4.vic_set        = 6'(set);
        bus4.vic_valid_mask = valid;
        bus4.vic_lock_mask  = lock;
        bus4.vic_alloc      = alloc;
        tick();
        bus4.vic_req   = 1'b0;
        bus4.vic_alloc = 1'b0;
        $display("query4 %s set=%0d valid=%b lock=%b way=%0d none=%0d", tag, set, valid, lock,
                 bus4.vic_way, bus4.vic_none);
        chk({tag, "_ack"}, 32'(bus4.vic_ack), 32'd1);
        chk({tag, "_way"}, 32'(bus4.vic_way), 32'(exp_way));
        chk({tag, "_none"}, 32'(bus4.vic_none), 32'(exp_none));
    endtask

    task automatic touch8(input int set, input int way);
        bus8.touch_valid = 1'b1;
        bus8.touch_set   = 4'(set);
        bus8.touch_way   = 3'(way);
        tick();
        bus8.touch_valid = 1'b0;
        $display("touch8 set=%0d way=%0d", set, way);
    endtask

    task automatic query8(input string tag, input int set, input logic [7:0] lock, input int exp_way);
        bus8.vic_req        = 1'b1;
        bus8.vic_set        = 4'(set);
        bus8.vic_valid_mask = 8'hFF;
        bus8.vic_lock_mask  = lock;
        tick();
        bus8.vic_req = 1'b0;
        $display("query8 %s set=%0d lock=%b way=%0d none=%0d", tag, set, lock,
                 bus8.vic_way, bus8.vic_none);
        chk({tag, "_ack"}, 32'(bus8.vic_ack), 32'd1);
        chk({tag, "_way"}, 32'(bus8.vic_way), 32'(exp_way));
    endtask

    initial begin
        bus4.touch_valid = 1'b0; bus4.touch_set = '0; bus4.touch_way = '0;
        bus4.vic_req = 1'b0; bus4.vic_set = '0; bus4.vic_valid_mask = '1;
        bus4.vic_lock_mask = '0; bus4.vic_alloc = 1'b0; bus4.inv = 1'b0; bus4.inv_set = '0;
        bus8.touch_valid = 1'b0; bus8.touch_set = '0; bus8.touch_way = '0;
        bus8.vic_req = 1'b0; bus8.vic_set = '0; bus8.vic_valid_mask = '1;
        bus8.vic_lock_mask = '0; bus8.vic_alloc = 1'b0; bus8.inv = 1'b0; bus8.inv_set = '0;

        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_ack", 32'(bus4.vic_ack), 32'd0);
        chk("rst_way", 32'(bus4.vic_way), 32'd0);
        chk("rst_none", 32'(bus4.vic_none), 32'd0);
        chk("rst_ack8", 32'(bus8.vic_ack), 32'd0);

        query4("post_rst", 0, 4'b1111, 4'b0000, 1'b0, 3, 1'b0);
        tick();
        chk("hold_ack", 32'(bus4.vic_ack), 32'd0);
        chk("hold_way", 32'(bus4.vic_way), 32'd3);

        touch4(0, 3);
        query4("after_t3", 0, 4'b1111, 4'b0000, 1'b0, 1, 1'b0);
        touch4(0, 1);
        query4("after_t1", 0, 4'b1111, 4'b0000, 1'b0, 2, 1'b0);
        query4("lock_hi", 0, 4'b1111, 4'b1100, 1'b0, 0, 1'b0);
        query4("lock_all", 0, 4'b1111, 4'b1111, 1'b1, 0, 1'b1);
        query4("unchanged", 0, 4'b1111, 4'b0000, 1'b0, 2, 1'b0);

        // Fresh set: invalid way 2 is filled and touched, so the walk then goes left/right.
        query4("alloc_inv", 1, 4'b1011, 4'b0000, 1'b1, 2, 1'b0);
        query4("after_alloc", 1, 4'b1111, 4'b0000, 1'b0, 1, 1'b0);
        query4("inv_locked", 2, 4'b0000, 4'b0001, 1'b0, 1, 1'b0);

        bus4.touch_valid = 1'b1; bus4.touch_set = 6'd5; bus4.touch_way = 2'd0;
        bus4.inv = 1'b1; bus4.inv_set = 6'd5;
        tick();
        bus4.touch_valid = 1'b0; bus4.inv = 1'b0;
        query4("inv_wins", 5, 4'b1111, 4'b0000, 1'b0, 3, 1'b0);

        bus4.touch_valid = 1'b1; bus4.touch_set = 6'd5; bus4.touch_way = 2'd3;
        bus4.vic_req = 1'b1; bus4.vic_set = 6'd6; bus4.vic_valid_mask = 4'b1111;
        bus4.vic_lock_mask = 4'b0000;
        tick();
        bus4.touch_valid = 1'b0; bus4.vic_req = 1'b0;
        chk("set6_ack", 32'(bus4.vic_ack), 32'd1);
        chk("set6_way", 32'(bus4.vic_way), 32'd3);
        query4("set5_touched", 5, 4'b1111, 4'b0000, 1'b0, 1, 1'b0);

        // A same-cycle touch to the queried set is not forwarded.
        bus4.touch_valid = 1'b1; bus4.touch_set = 6'd7; bus4.touch_way = 2'd3;
        bus4.vic_req = 1'b1; bus4.vic_set = 6'd7;
        tick();
        bus4.touch_valid = 1'b0; bus4.vic_req = 1'b0;
        chk("nofwd_way", 32'(bus4.vic_way), 32'd3);
        query4("nofwd_after", 7, 4'b1111, 4'b0000, 1'b0, 1, 1'b0);

        query8("w8_post_rst", 0, 8'h00, 7);
        touch8(3, 7);
        query8("w8_after_t7", 3, 8'h00, 3);
        query8("w8_lock_hi", 0, 8'hF0, 3);

        rst_i = 1'b1;
        bus4.vic_req = 1'b1; bus4.vic_set = 6'd0;
        bus4.touch_valid = 1'b1; bus4.touch_set = 6'd0; bus4.touch_way = 2'd3;
        bus8.vic_req = 1'b1; bus8.vic_set = 4'd3;
        tick();
        rst_i = 1'b0;
        bus4.vic_req = 1'b0; bus4.touch_valid = 1'b0; bus8.vic_req = 1'b0;
        chk("midrst_ack", 32'(bus4.vic_ack), 32'd0);
        chk("midrst_ack8", 32'(bus8.vic_ack), 32'd0);
        query4("rst_set0", 0, 4'b1111, 4'b0000, 1'b0, 3, 1'b0);
        query4("rst_set1", 1, 4'b1111, 4'b0000, 1'b0, 3, 1'b0);
        query4("rst_set5", 5, 4'b1111, 4'b0000, 1'b0, 3, 1'b0);
        query4("rst_set7", 7, 4'b1111, 4'b0000, 1'b0, 3, 1'b0);
        query8("w8_rst_set3", 3, 8'h00, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
